// File: rtl/glitch_sequencer.sv
// Programmable glitch/parallel-output sequencer driven by an external instruction ROM.
// Each word either drives a byte plus glitch strobe for a timed interval, jumps, waits on a trigger, or halts.
module glitch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DELAY_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               trigger,
    output logic [ADDR_W-1:0]  instr_pt,
    input  logic [11:0]        instr,
    input  logic [DELAY_W-1:0] delay_len,
    output logic [7:0]         parallel_out,
    output logic               glitch,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAITTRIG,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_OUT      = 3'b000;
    localparam logic [2:0] OP_JUMP     = 3'b010;
    localparam logic [2:0] OP_WAITTRIG = 3'b011;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pt_next;
    logic [7:0]         pout_next;
    logic               glitch_next;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] cnt_next;

    logic [2:0]         opcode;
    logic [7:0]         data_byte;
    logic               glitch_bit;
    logic [ADDR_W-1:0]  jump_target;
    logic [DELAY_W-1:0] delay_load;

    assign opcode      = instr[11:9];
    assign data_byte   = instr[8:1];
    assign glitch_bit  = instr[0];
    assign jump_target = ADDR_W'(data_byte);
    // A zero delay still occupies one EXEC cycle.
    assign delay_load  = (delay_len == '0) ? DELAY_W'(1) : delay_len;

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            instr_pt     <= '0;
            parallel_out <= '0;
            glitch       <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_next;
            instr_pt     <= pt_next;
            parallel_out <= pout_next;
            glitch       <= glitch_next;
            cnt          <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        pt_next     = instr_pt;
        pout_next   = parallel_out;
        glitch_next = glitch;
        cnt_next    = cnt;

        if (abort) begin
            state_next  = S_IDLE;
            pt_next     = '0;
            pout_next   = '0;
            glitch_next = 1'b0;
            cnt_next    = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next = S_FETCH;
                        pt_next    = '0;
                    end
                end
                S_FETCH: begin
                    // The ROM word is decoded and captured on the edge that ends FETCH.
                    case (opcode)
                        OP_OUT: begin
                            state_next  = S_EXEC;
                            pout_next   = data_byte;
                            glitch_next = glitch_bit;
                            cnt_next    = delay_load;
                        end
                        OP_JUMP: begin
                            state_next = S_FETCH;
                            pt_next    = jump_target;
                        end
                        OP_WAITTRIG: begin
                            state_next = S_WAITTRIG;
                        end
                        default: begin
                            state_next  = S_DONE;
                            glitch_next = 1'b0;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (cnt <= DELAY_W'(1)) begin
                        state_next  = S_FETCH;
                        pt_next     = instr_pt + ADDR_W'(1);
                        glitch_next = 1'b0;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt - DELAY_W'(1);
                    end
                end
                S_WAITTRIG: begin
                    if (trigger) begin
                        state_next = S_FETCH;
                        pt_next    = instr_pt + ADDR_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule
